// File: rtl/dct_pkg.sv
// Shared definitions for the DCT output path: block geometry and the packed
// FIFO word that carries one coefficient pair plus its end-of-block marker.
package dct_pkg;

    localparam int RUNL_STAGE_WIDTH = 16;
    localparam int PAIRS_PER_BLOCK  = 32;
    localparam int COEFFS_PER_BLOCK = 2 * PAIRS_PER_BLOCK;

    typedef struct packed {
        logic                        last;
        logic [RUNL_STAGE_WIDTH-1:0] odd;
        logic [RUNL_STAGE_WIDTH-1:0] even;
    } dct_word_t;

endpackage

// File: rtl/dct_axis_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head word lives in an
// output register that reloads on the same edge as a pop, giving 1 word/cycle.
module dct_axis_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      level_q;
    logic [AW:0]      held;
    logic [AW:0]      level_nxt;
    logic             push_ok;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    // NOTE: always_comb uses blocking '=' so later lines see earlier results;
    // clocked blocks use '<=' so all registers update together at the edge.
    always_comb begin
        push_ok    = push && (!full || pop);
        rd_ptr_nxt = rd_ptr + AW'(pop);
        held       = level_q - (AW+1)'(pop);
        level_nxt  = held + (AW+1)'(push_ok);
    end

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;

    // NOTE: the storage array is deliberately left out of reset; stale words
    // are unreachable once pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            empty    <= 1'b1;
            pop_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            level_q <= level_nxt;
            empty   <= (level_nxt == '0);
            // Next head is already in memory, or is the word arriving now.
            if (held != '0) begin
                pop_data <= mem[rd_ptr_nxt];
            end else if (push_ok) begin
                pop_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/dct_axis_packer.sv
// Packs dct_main run-length coefficient pairs into 32-bit AXI4-Stream words,
// marking each block's final word with tlast and flagging pairs lost to a stall.
module dct_axis_packer #(
    parameter int RUNL_STAGE_WIDTH = dct_pkg::RUNL_STAGE_WIDTH,
    parameter int FIFO_DEPTH       = 64,
    parameter int PAIRS_PER_BLOCK  = dct_pkg::PAIRS_PER_BLOCK
) (
    input  logic                          i_clk,
    input  logic                          i_resetn,
    input  logic [RUNL_STAGE_WIDTH-1:0]   rdata0,
    input  logic [RUNL_STAGE_WIDTH-1:0]   rdata1,
    input  logic                          rsync,
    output logic [2*RUNL_STAGE_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
);

    localparam int DW = 2 * RUNL_STAGE_WIDTH;
    localparam int CW = $clog2(PAIRS_PER_BLOCK);
    localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS_PER_BLOCK - 1);

    logic [CW-1:0] pair_cnt;
    logic [DW:0]   push_word;
    logic [DW:0]   head_word;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;

    assign push_word = {pair_cnt == LAST_PAIR, rdata1, rdata0};
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign drop      = rsync && fifo_full && !pop;

    dct_axis_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_resetn),
        .push      (rsync),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = head_word[DW];
    assign m_axis_tdata  = head_word[DW-1:0];

    // The counter advances even on a dropped pair so tlast stays block-aligned.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            pair_cnt   <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (rsync) begin
                pair_cnt <= (pair_cnt == LAST_PAIR) ? '0 : pair_cnt + CW'(1);
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_axis_packer.sv
// Directed bench for dct_axis_packer: a queue model tracks accepted words and
// every cycle's outputs are compared, plus hand-computed spot checks.
module tb_dct_axis_packer;
    import dct_pkg::*;

    localparam int DEPTH = 64;
    localparam int PPB   = 32;

    logic        i_clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic [15:0] rdata0 = '0;
    logic [15:0] rdata1 = '0;
    logic        rsync = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic [6:0]  o_level;
    logic        o_overflow;

    int total = 0;
    int bad = 0;

    dct_word_t exp_q[$];
    int        exp_cnt = 0;
    logic      exp_ovf = 1'b0;
    int        words_seen = 0;
    int        lasts_seen = 0;

    always #5 i_clk = ~i_clk;

    dct_axis_packer #(
        .RUNL_STAGE_WIDTH (16),
        .FIFO_DEPTH       (DEPTH),
        .PAIRS_PER_BLOCK  (PPB)
    ) dut (
        .i_clk         (i_clk),
        .i_resetn      (i_resetn),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .rsync         (rsync),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .o_level       (o_level),
        .o_overflow    (o_overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("tvalid", tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("tdata", tdata, {exp_q[0].odd, exp_q[0].even});
            check("tlast", tlast, exp_q[0].last);
        end
        check("level", o_level, exp_q.size());
        check("overflow", o_overflow, exp_ovf);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic cycle(input logic s, input logic [15:0] d0, input logic [15:0] d1, input logic rdy);
        logic      do_pop;
        dct_word_t w;
        rsync  = s;
        rdata0 = d0;
        rdata1 = d1;
        tready = rdy;
        do_pop = (exp_q.size() != 0) && rdy;
        if (tvalid && rdy) begin
            words_seen++;
            if (tlast) lasts_seen++;
        end
        @(posedge i_clk);
        if (do_pop) void'(exp_q.pop_front());
        if (s) begin
            w.last = (exp_cnt == PPB - 1);
            w.odd  = d1;
            w.even = d0;
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else exp_ovf = 1'b1;
            exp_cnt = (exp_cnt + 1) % PPB;
        end
        #1;
        check_outputs();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_level"}, o_level, 0);
        check({tag, "_overflow"}, o_overflow, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check_zero_outputs("reset");
        i_resetn = 1'b1;

        // Single block with tready high: word k visible one cycle after input
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 16'(k), 16'(k + 100), 1'b1);
            check("blk_word", tdata, {16'(k + 100), 16'(k)});
            check("blk_last", tlast, k == 31);
        end
        cycle(1'b0, '0, '0, 1'b1);
        check("blk_idle_tvalid", tvalid, 0);

        // Stall absorption: head word stays put while level climbs
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 16'(k + 200), 16'(k + 300), 1'b0);
            check("stall_level", o_level, k + 1);
            check("stall_head", tdata, {16'd300, 16'd200});
        end
        for (int k = 0; k < 32; k++) begin
            check("drain_word", tdata, {16'(k + 300), 16'(k + 200)});
            cycle(1'b0, '0, '0, 1'b1);
        end
        check("drain_empty", tvalid, 0);

        // Overflow: 65 pairs into a 64-deep FIFO, 65th is dropped
        for (int k = 0; k < 65; k++) begin
            cycle(1'b1, 16'(k + 1000), 16'(k + 2000), 1'b0);
        end
        check("ovf_level", o_level, 64);
        check("ovf_flag", o_overflow, 1);
        for (int k = 0; k < 64; k++) begin
            check("ovf_drain", tdata, {16'(k + 2000), 16'(k + 1000)});
            cycle(1'b0, '0, '0, 1'b1);
        end
        check("ovf_drained", tvalid, 0);
        // The dropped pair opened the next block; 31 more complete it
        for (int k = 1; k < 32; k++) begin
            cycle(1'b1, 16'(k + 3000), 16'(k + 4000), 1'b1);
            check("ovf_align_last", tlast, k == 31);
        end
        check("ovf_sticky", o_overflow, 1);

        // Reset mid-block during a stall
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 16'(k + 5000), 16'(k + 6000), 1'b0);
        end
        rsync    = 1'b0;
        i_resetn = 1'b0;
        #1;
        check_zero_outputs("midrst");
        exp_q.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        @(posedge i_clk);
        #3;
        i_resetn = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 16'(k + 7000), 16'(k + 8000), 1'b1);
            check("rst_blk_last", tlast, k == 31);
        end
        cycle(1'b0, '0, '0, 1'b1);

        // Full FIFO with simultaneous push and pop: accepted, no overflow
        for (int k = 0; k < 64; k++) begin
            cycle(1'b1, 16'(k + 9000), 16'(k + 10000), 1'b0);
        end
        check("full_level", o_level, 64);
        cycle(1'b1, 16'hAAAA, 16'h5555, 1'b1);
        check("full_pp_level", o_level, 64);
        check("full_pp_ovf", o_overflow, 0);
        check("full_pp_head", tdata, {16'd10001, 16'd9001});
        for (int k = 0; k < 64; k++) begin
            cycle(1'b0, '0, '0, 1'b1);
        end
        check("full_pp_empty", tvalid, 0);

        // Gapped input with random tready; counter restarts at 1 after extra pair
        for (int k = 1; k < 32; k++) begin
            cycle(1'b1, 16'(k + 11000), 16'(k + 12000), 1'b1);
        end
        cycle(1'b0, '0, '0, 1'b1);
        check("gap_pre_empty", tvalid, 0);
        words_seen = 0;
        lasts_seen = 0;
        for (int i = 0; i < 128; i++) begin
            cycle(i % 2 == 0, 16'(i + 13000), 16'(i + 14000), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            cycle(1'b0, '0, '0, 1'b1);
        end
        cycle(1'b0, '0, '0, 1'b1);
        check("gap_empty", tvalid, 0);
        check("gap_words", words_seen, 64);
        check("gap_lasts", lasts_seen, 2);
        check("gap_ovf", o_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_axis_packer.md
# dct_axis_packer

Output stage directly downstream of `dct_main`. It captures the run-length coefficient pairs that `dct_main` emits on `rdata0`/`rdata1` whenever `rsync` is high. Each pair is packed into one 32-bit word and buffered in a synchronous FIFO. Words are presented on an AXI4-Stream master port, with `tlast` marking the final word of every 8×8 block. `dct_main` has no backpressure, so this block absorbs downstream stalls and flags any loss.

## Interface
- `RUNL_STAGE_WIDTH`, 16: width of each run-length coefficient from `dct_main`.
- `FIFO_DEPTH`, 64: FIFO depth in words; must be a power of two ≥ 32 (default holds two blocks).
- `PAIRS_PER_BLOCK`, 32: coefficient pairs per 8×8 block.
---
- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_resetn`  in  1  asynchronous, active-low reset.
- `rdata0`  in  RUNL_STAGE_WIDTH  even coefficient of pair.
- `rdata1`  in  RUNL_STAGE_WIDTH  odd coefficient of pair.
- `rsync`  in  1  pair valid this cycle; no backpressure exists.
- `m_axis_tdata`  out  2*RUNL_STAGE_WIDTH  packed word `{rdata1, rdata0}`.
- `m_axis_tvalid`  out  1  word available.
- `m_axis_tready`  in  1  downstream accepts.
- `m_axis_tlast`  out  1  last word of a block.
- `o_level`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `o_overflow`  out  1  sticky: a pair was dropped.

## Operation
- **Push**: occurs on the rising edge where `rsync`=1. Stored entry is `{pair_cnt==PAIRS_PER_BLOCK-1, rdata1, rdata0}`; the tlast bit is stored with the data.
- **Pair counter**:
  - `pair_cnt` (0..PAIRS_PER_BLOCK-1) increments on every `rsync`, whether the push is accepted or dropped.
  - It wraps to 0 after PAIRS_PER_BLOCK-1, so block alignment survives a drop.
- **Pop**: occurs on the edge where `m_axis_tvalid && m_axis_tready`.
- **Full rule**: a push is accepted if `level < FIFO_DEPTH`, or if `level == FIFO_DEPTH` and a pop occurs in the same cycle.
- **Drop**: if a push is not accepted, the pair is discarded and `o_overflow` is set. It is cleared only by reset.
- **Simultaneous push and pop**: level is unchanged and both pointers advance.
- **Empty**: `m_axis_tvalid`=0. `tdata`/`tlast` hold their last value and are don't-care for checking.
- **AXIS rule**: once `tvalid` is asserted, `tdata`/`tlast`/`tvalid` stay stable until the handshake completes.
- **Pointers**: log2(FIFO_DEPTH) bits and wrap naturally. Level is tracked in a separate counter.
- **Reset** (asynchronous, any time, including mid-block or mid-stall):
  - pointers, level and `pair_cnt` go to 0;
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `o_overflow`=0, `o_level`=0;
  - FIFO contents are discarded.

## Timing
- Latency is 1 cycle: a pair pushed at edge N is visible on `m_axis_*` with `tvalid`=1 after edge N, when the FIFO was empty.
- The output register is a FWFT skid. It reloads on the same edge as a pop, so sustained throughput is 1 word/cycle with `tready` held high.
- `o_level` is registered and reflects the edge just taken.
- `o_overflow` asserts the cycle after the dropped `rsync`.
- No combinational path exists from `m_axis_tready` to `m_axis_tvalid`/`tdata`.

## Structure
- Shared package `dct_pkg`:
  - `PAIRS_PER_BLOCK` (32) and `COEFFS_PER_BLOCK` (64);
  - typedef `dct_word_t` (2*RUNL_STAGE_WIDTH data + 1 last bit).
- One sub-module, `dct_axis_fifo`: a generic synchronous FWFT FIFO with push/pop/full/empty/level.
- The packer itself holds only `pair_cnt`, the overflow flag and the word formation.
- Total RTL is roughly 200 lines.

## Test plan
- **Single block, tready=1**: 32 consecutive `rsync` pairs (k, k+100), k=0..31.
  - Expect 32 words `{k+100,k}`, each one cycle after its input.
  - `tlast`=1 only on word 31; `o_overflow`=0.
- **Stall absorption**: tready=0 during one block.
  - `o_level` climbs to 32 and `tvalid` stays high with word 0 stable.
  - After release, 32 words drain in order, one per cycle.
- **Overflow**: tready=0 for 65 `rsync` pairs (FIFO_DEPTH=64).
  - `o_level`=64 and `o_overflow`=1 after the 65th pair.
  - The 65th pair is absent from the drained stream.
  - The next block's `tlast` still falls on its 32nd input pair.
- **Full with simultaneous push and pop**: level=64, then tready=1 and `rsync`=1 in the same cycle.
  - Push accepted, level stays 64, no overflow.
- **Gapped input**: `rsync` toggling 1/0 with random tready.
  - Output order is preserved and `tlast` appears every 32 words.
- **Reset mid-block**: assert `i_resetn`=0 after 10 pairs with tready=0.
  - All outputs go to 0 immediately.
  - After release, a fresh 32-pair block gives `tlast` on its 32nd word.
